// File: rtl/bft_stream_tx.sv
// bft_stream_tx: turns a 32-bit valid/ack user stream into 49-bit BFT packets
// addressed to one fixed leaf/port. It consumes one receiver-buffer credit per
// packet and replenishes credits from freespace-update packets on the return path.
// Optional feature macro: BFT_TX_STATS_EN (sent-packet counter on pkt_count).
module bft_stream_tx #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_BRAM_ADDR_BITS    = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64,
  parameter int SELF_LEAF             = 0,
  parameter int DEST_LEAF             = 2,
  parameter int DEST_PORT             = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [PAYLOAD_BITS-1:0]       din_user,
  input  logic                          vld_user,
  output logic                          ack_user,
  input  logic [PACKET_BITS-1:0]        din_leaf_bft2tx,
  output logic [PACKET_BITS-1:0]        dout_leaf_tx2bft,
  input  logic                          resend,
  output logic [NUM_BRAM_ADDR_BITS:0]   credits,
  output logic [31:0]                   pkt_count
);

  // Credit counter is one bit wider than the buffer address so it can hold 2^N.
  localparam int CW = NUM_BRAM_ADDR_BITS + 1;
  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(1 << NUM_BRAM_ADDR_BITS);

  // Packet field offsets: [valid | leaf | port | addr | payload].
  localparam int ADDR_LSB = PAYLOAD_BITS;
  localparam int PORT_LSB = ADDR_LSB + NUM_ADDR_BITS;
  localparam int LEAF_LSB = PORT_LSB + NUM_PORT_BITS;
  localparam int VLD_BIT  = PACKET_BITS - 1;

  localparam logic [NUM_LEAF_BITS-1:0] SELF_L = NUM_LEAF_BITS'(SELF_LEAF);
  localparam logic [NUM_LEAF_BITS-1:0] DEST_L = NUM_LEAF_BITS'(DEST_LEAF);
  localparam logic [NUM_PORT_BITS-1:0] DEST_P = NUM_PORT_BITS'(DEST_PORT);
  localparam logic [31:0]              FSU_W  = 32'(FREESPACE_UPDATE_SIZE);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e                     state_q;
  logic [CW-1:0]              credits_q, credits_d;
  logic [NUM_ADDR_BITS-1:0]   wr_addr_q;
  logic [PACKET_BITS-1:0]     dout_q;

  logic                       credit_pkt;
  logic [CW-1:0]              grant;
  logic                       send;
  logic [CW:0]                credit_sum;

  // Only valid/leaf/port and the low payload byte of a return packet matter;
  // the remaining bits and the nominal grant size are informational.
  logic unused_bits;
  assign unused_bits = ^{din_leaf_bft2tx[PORT_LSB-1:CW], FSU_W};

  // Decode a freespace update addressed to this leaf's port 0.
  always_comb begin
    credit_pkt = din_leaf_bft2tx[VLD_BIT] &&
                 (din_leaf_bft2tx[LEAF_LSB +: NUM_LEAF_BITS] == SELF_L) &&
                 (din_leaf_bft2tx[PORT_LSB +: NUM_PORT_BITS] == '0);
    grant      = credit_pkt ? din_leaf_bft2tx[CW-1:0] : '0;
  end

  // Accept a user word only with credit in hand and no hold from the network.
  // Gated by reset so the producer never sees an ack that reset would discard.
  assign send     = vld_user & (credits_q != '0) & ~resend & ~reset;
  assign ack_user = send;

  // Next credit count: add grant, subtract send in a wider sum, clamp to buffer depth.
  always_comb begin
    credit_sum = {1'b0, credits_q} + {1'b0, grant} - (CW+1)'(send);
    credits_d  = (credit_sum > CREDIT_MAX) ? CREDIT_MAX[CW-1:0] : credit_sum[CW-1:0];
  end

  // Datapath registers: credit count, write address, and the one-cycle output word.
  always_ff @(posedge clk) begin
    if (reset) begin
      credits_q <= CREDIT_MAX[CW-1:0];
      wr_addr_q <= '0;
      dout_q    <= '0;
    end else begin
      credits_q <= credits_d;
      if (send) begin
        wr_addr_q <= wr_addr_q + 1'b1;
        dout_q    <= {1'b1, DEST_L, DEST_P, wr_addr_q, din_user};
      end else begin
        dout_q    <= '0;
      end
    end
  end

  // Flow-control state: HOLD while the network asks for resend, STALL when out of credit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (resend)                 state_q <= ST_HOLD;
          else if (credits_d == '0)   state_q <= ST_STALL;
        end
        ST_STALL: begin
          if (resend)                 state_q <= ST_HOLD;
          else if (credits_d != '0)   state_q <= ST_RUN;
        end
        ST_HOLD: begin
          if (!resend)                state_q <= (credits_d == '0) ? ST_STALL : ST_RUN;
        end
        default:                      state_q <= ST_RUN;
      endcase
    end
  end

  // resend kills the registered word on the wire; it is not replayed.
  assign dout_leaf_tx2bft = resend ? '0 : dout_q;
  assign credits          = credits_q;

`ifdef BFT_TX_STATS_EN
  logic [31:0] pkt_count_q;

  // Free-running count of packets handed to the network.
  always_ff @(posedge clk) begin
    if (reset)     pkt_count_q <= '0;
    else if (send) pkt_count_q <= pkt_count_q + 32'd1;
  end

  assign pkt_count = pkt_count_q;
`else
  assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_bft_stream_tx.sv
// Bench for bft_stream_tx: directed scenarios plus a randomized phase, every
// cycle compared against a credit/address/packet reference model.
module tb_bft_stream_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] din_user;
  logic        vld_user;
  logic        ack_user;
  logic [48:0] din_leaf_bft2tx;
  logic [48:0] dout_leaf_tx2bft;
  logic        resend;
  logic [7:0]  credits;
  logic [31:0] pkt_count;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  int          m_cred;
  int          m_addr;
  int          m_cnt;
  logic [48:0] m_prev;

  always #5 clk = ~clk;

  bft_stream_tx dut (
    .clk              (clk),
    .reset            (reset),
    .din_user         (din_user),
    .vld_user         (vld_user),
    .ack_user         (ack_user),
    .din_leaf_bft2tx  (din_leaf_bft2tx),
    .dout_leaf_tx2bft (dout_leaf_tx2bft),
    .resend           (resend),
    .credits          (credits),
    .pkt_count        (pkt_count)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [48:0] cpkt(input int leaf, input int port, input int g);
    logic [4:0] l;
    logic [3:0] p;
    logic [7:0] gg;
    l = 5'(leaf); p = 4'(port); gg = 8'(g);
    return {1'b1, l, p, 7'd0, 24'd0, gg};
  endfunction

  function automatic int exp_pkt_count();
`ifdef BFT_TX_STATS_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_cred = 128; m_addr = 0; m_cnt = 0; m_prev = '0;
  endtask

  // One clock cycle: apply inputs, check outputs mid-cycle, advance the model.
  task automatic step(input logic v, input logic [31:0] d, input logic rs, input logic [48:0] cin);
    logic        e_ack;
    int          g;
    vld_user = v; din_user = d; resend = rs; din_leaf_bft2tx = cin;
    @(negedge clk);
    e_ack = v && (m_cred > 0) && !rs;
    chk("ack", 64'(ack_user), 64'(e_ack));
    chk("dout", 64'(dout_leaf_tx2bft), rs ? 64'd0 : 64'(m_prev));
    chk("credits", 64'(credits), 64'(m_cred));
    chk("pkt_count", 64'(pkt_count), 64'(exp_pkt_count()));
    g = (cin[48] && cin[47:43] == 5'd0 && cin[42:39] == 4'd0) ? int'(cin[7:0]) : 0;
    m_cred = m_cred + g - (e_ack ? 1 : 0);
    if (m_cred > 128) m_cred = 128;
    m_prev = e_ack ? {1'b1, 5'd2, 4'd1, 7'(m_addr), d} : 49'd0;
    if (e_ack) begin
      m_addr = (m_addr + 1) % 128;
      m_cnt++;
    end
    @(posedge clk); #1;
  endtask

  // Reset for one edge with vld_user high; the registered word must be dropped.
  task automatic do_reset();
    reset = 1'b1; vld_user = 1'b1; din_user = 32'hDEAD_BEEF; resend = 1'b0;
    din_leaf_bft2tx = '0;
    @(negedge clk);
    chk("rst_ack", 64'(ack_user), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0; vld_user = 1'b0;
    model_reset();
    chk("rst_dout", 64'(dout_leaf_tx2bft), 64'd0);
    chk("rst_credits", 64'(credits), 64'd128);
    chk("rst_pkt_count", 64'(pkt_count), 64'd0);
  endtask

  initial begin
    reset = 1'b1; vld_user = 1'b0; din_user = '0; resend = 1'b0; din_leaf_bft2tx = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Four words right after reset, then an idle cycle to see the last one.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h11 + 32'(i), 1'b0, '0);
    step(1'b0, '0, 1'b0, '0);
    chk("cred_after4", 64'(credits), 64'd124);

    // Drain all credits, hold vld high past zero, then return 64.
    while (m_cred > 0) step(1'b1, $urandom, 1'b0, '0);
    repeat (3) step(1'b1, $urandom, 1'b0, '0);
    chk("zero_credits", 64'(credits), 64'd0);
    step(1'b1, $urandom, 1'b0, cpkt(0, 0, 64));
    chk("wrap_addr", 64'(m_addr), 64'd0);
    step(1'b1, 32'hCAFE_0001, 1'b0, '0);

    // Down to one credit, then send and grant together.
    while (m_cred > 1) step(1'b1, $urandom, 1'b0, '0);
    step(1'b1, $urandom, 1'b0, cpkt(0, 0, 64));
    chk("grant_at_one", 64'(credits), 64'd64);
    step(1'b1, $urandom, 1'b0, '0);

    // resend for three cycles mid-stream with a credit packet inside.
    step(1'b1, $urandom, 1'b0, '0);
    step(1'b1, $urandom, 1'b1, '0);
    step(1'b1, $urandom, 1'b1, cpkt(0, 0, 5));
    step(1'b1, $urandom, 1'b1, '0);
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, '0);

    // Reach 100 credits, then over-grant and send foreign packets.
    while (m_cred > 100) step(1'b1, $urandom, 1'b0, '0);
    if (m_cred < 100) step(1'b0, '0, 1'b0, cpkt(0, 0, 100 - m_cred));
    step(1'b0, '0, 1'b0, cpkt(0, 0, 64));
    step(1'b0, '0, 1'b0, '0);
    chk("saturate", 64'(credits), 64'd128);
    step(1'b1, $urandom, 1'b0, cpkt(3, 0, 64));
    step(1'b1, $urandom, 1'b0, cpkt(0, 2, 64));
    step(1'b0, '0, 1'b0, {1'b0, cpkt(0, 0, 64)} >> 0 & 49'h0_FFFF_FFFF_FFFF);
    step(1'b0, '0, 1'b0, '0);
    chk("ignored_pkts", 64'(credits), 64'd126);

    // Randomized traffic with occasional resend and mixed return packets.
    for (int i = 0; i < 600; i++) begin
      logic [48:0] c;
      c = '0;
      if ($urandom_range(0, 9) == 0)
        c = cpkt($urandom_range(0, 1) ? 0 : 3, $urandom_range(0, 3) == 0 ? 1 : 0,
                 $urandom_range(0, 40));
      if ($urandom_range(0, 7) == 0) c[48] = 1'b0;
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 9) == 0, c);
    end

    // Packet counter across a mid-stream reset.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, '0);
    step(1'b0, '0, 1'b0, '0);
`ifdef BFT_TX_STATS_EN
    chk("pkt_count_10", 64'(pkt_count), 64'd10);
`else
    chk("pkt_count_off", 64'(pkt_count), 64'd0);
`endif
    step(1'b1, 32'h200, 1'b0, '0);
    do_reset();
    step(1'b0, '0, 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Watchdog against a stuck run.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bft_stream_tx.md
# bft_stream_tx

- Sources packets onto the BFT network toward one fixed destination leaf/port.
- Converts a 32-bit user valid/ack stream into 49-bit BFT packets and tracks receiver buffer credits returned through freespace-update packets.
- Sits on the network side opposite a leaf's receive port: it is the transmitter feeding the leaf-interface input path, and is used in DMA/host-side shells and in loopback test harnesses.

## Interface
- PACKET_BITS, 49, BFT packet width
- PAYLOAD_BITS, 32, payload width
- NUM_LEAF_BITS, 5, leaf field width
- NUM_PORT_BITS, 4, port field width
- NUM_ADDR_BITS, 7, address field width
- NUM_BRAM_ADDR_BITS, 7, receiver buffer depth is 2^this (128 words)
- FREESPACE_UPDATE_SIZE, 64, nominal credit grant per update (documentation only; the grant is taken from the packet)
- SELF_LEAF, 0, this block's leaf number, matched on incoming credit packets
- DEST_LEAF, 2, destination leaf
- DEST_PORT, 1, destination input port (must be nonzero)
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- din_user  in  32  payload from producer
- vld_user  in  1  payload valid
- ack_user  out  1  payload accepted this cycle
- din_leaf_bft2tx  in  49  incoming packets carrying credit returns
- dout_leaf_tx2bft  out  49  outgoing packets
- resend  in  1  network resend/hold request
- credits  out  8  current credit count
- pkt_count  out  32  packets sent (see Configuration)

## Operation
- Packet format: [48] valid, [47:43] leaf, [42:39] port, [38:32] addr, [31:0] payload.
- Outgoing packet: {1, DEST_LEAF, DEST_PORT, wr_addr, din_user}.
- wr_addr is a 7-bit counter, +1 per sent packet, wrapping 127→0.
- Credit counter:
  - 8 bits, reset to 128 (2^NUM_BRAM_ADDR_BITS).
  - Each sent packet consumes one credit.
- Credit packet: a din_leaf_bft2tx word with [48]=1, leaf==SELF_LEAF and port==0.
  - Grant = payload[7:0].
  - Any other incoming word is ignored.
- Counter update each cycle:
  - credits_next = min(128, credits + grant − send).
  - Computed in 9 bits, then saturated at 128.
- Accept condition: send = vld_user & (credits != 0) & ~resend.
  - ack_user = send, combinational.
- State machine (state register, 2 bits):
  - RUN: credits ≠ 0 and resend low.
  - STALL: entered when credits would reach 0. Exits to RUN the cycle after any grant > 0.
  - HOLD: entered whenever resend is high, from any state. Returns to RUN or STALL per credits once resend falls.
- During HOLD:
  - Credit packets are still absorbed.
  - wr_addr and credits are otherwise frozen.

## Timing
- Reset (synchronous):
  - dout_leaf_tx2bft=0, ack_user=0, credits=128, wr_addr=0, pkt_count=0, state=RUN.
  - Reset asserted mid-stream drops the in-flight output word at the next edge.
- Latency: payload accepted at edge N appears on dout_leaf_tx2bft after edge N (registered), for exactly one cycle.
  - Output is 0 in cycles with no send.
- Back-to-back: one packet per cycle is sustained while credits last.
- resend:
  - Forces dout_leaf_tx2bft to 0 combinationally, including a word registered in the previous cycle.
  - The suppressed word is lost. The producer never sees a second ack for it; the end-to-end protocol handles recovery.
- Credit timing:
  - A credit packet arriving at edge N is usable for send in cycle N+1.
  - A simultaneous grant and send at credits=1 leaves credits=grant, with no stall cycle.
- Saturation: a grant that would exceed 128 clamps to 128. No error flag.
- Zero-credit boundary: with credits=1 and vld_user held high, exactly one more ack occurs, then ack_user stays low.

## Configuration
- BFT_TX_STATS_EN defined:
  - pkt_count increments by 1 per sent packet and wraps at 2^32.
  - Cleared by reset.
- Not defined: pkt_count is tied to 0 and no counter logic is synthesized.

## Test plan
- After reset, 4 words 0x11..0x14 with vld_user high → dout one cycle later = {1,5'd2,4'd1,addr 0..3,payload}; credits=124.
- Send 128 words with no credit returns → 128 acks, then ack_user low. Then inject credit packet {1,5'd0,4'd0,7'd0,32'd64} → sends resume next cycle; wr_addr wrapped to 0 at word 128.
- At credits=1, simultaneous send and grant of 64 → credits=64 and no stall cycle.
- Assert resend for 3 cycles mid-stream → dout=0 and ack_user=0 throughout; a credit packet during resend is still counted; streaming resumes with addr continuity.
- At credits=100, grant of 64 → credits=128 (saturated). Credit packet with leaf=3 → ignored.
- With BFT_TX_STATS_EN, send 10 packets then reset → pkt_count=10 before reset and 0 after. Without the macro, pkt_count=0 always.
